rv_decode_stage: RTL and testbench

Pipelined RV32I/M integer-ALU decode stage with valid/ready handshakes on both sides. It accepts a 32-bit instruction plus a tag and decodes OP (0110011) and OP-IMM (0010011) instructions into ALU control fields. It registers the result through a 2-entry skid buffer so upstream `in_ready` is a flop. It sits between fetch and the register-read/execute stage, and keeps a saturating count of illegal instructions it has issued.

---
 rtl/rv_decode_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// rv_decode_stage
// ---------------------------------------------------------------------------
// Integer-ALU decode stage for RV32I with optional M extension. It decodes OP
// (0110011) and OP-IMM (0010011) instruction words into ALU control fields.
// Each decoded entry passes through a two-entry buffer: an output register
// and one skid entry. Because of the skid entry, in_ready comes straight
// from a flop. The stage also keeps a saturating count of illegal entries
// that it has handed downstream.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until that edge. in_ready depends only on registered state, never
// on out_ready.
//
// Ports
//   clk            : clock, all state on the rising edge
//   rst            : asynchronous active-high reset
//   flush          : synchronous discard of both entries; blocks accept
//   in_valid       : upstream instruction valid
//   in_ready       : stage can accept (skid entry empty)
//   in_instr[31:0] : instruction word
//   in_tag         : side-band tag carried unchanged
//   out_valid      : decoded entry valid
//   out_ready      : downstream accepts
//   out_alu_op[4:0]: ALU operation code (M ops are 16 + funct3)
//   out_src_imm    : operand B is the immediate
//   out_reg_write  : entry writes rd
//   out_mdu        : entry goes to the multiply/divide unit
//   out_illegal    : unsupported or malformed instruction
//   out_tag        : tag of the entry
//   illegal_count  : saturating count of issued illegal entries
// ---------------------------------------------------------------------------
module rv_decode_stage #(
    parameter bit ENABLE_M = 1'b1,
    parameter int TAG_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_alu_op,
    output logic             out_src_imm,
    output logic             out_reg_write,
    output logic             out_mdu,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [4:0]       alu_op;
        logic             src_imm;
        logic             reg_write;
        logic             mdu;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // funct3 -> operation for the non-alternate encodings shared by OP and OP-IMM
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_legal;
    logic [4:0] w_op;
    logic       w_imm;
    logic       w_mdu;
    entry_t     w_dec;
    logic       w_unused_fields;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    // Register specifiers and immediates do not affect ALU control.
    assign w_unused_fields = ^{in_instr[24:15], in_instr[11:7]};

    always_comb begin
        w_legal = 1'b0;
        w_op    = ALU_ADD;
        w_imm   = 1'b0;
        w_mdu   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                case (w_funct7)
                    F7_BASE: begin
                        w_legal = 1'b1;
                        w_op    = base_op(w_funct3);
                    end
                    F7_ALT: begin
                        if (w_funct3 == 3'b000) begin
                            w_legal = 1'b1;
                            w_op    = ALU_SUB;
                        end else if (w_funct3 == 3'b101) begin
                            w_legal = 1'b1;
                            w_op    = ALU_SRA;
                        end
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            w_legal = 1'b1;
                            w_mdu   = 1'b1;
                            w_op    = {2'b10, w_funct3};
                        end
                    end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                w_imm = 1'b1;
                case (w_funct3)
                    // funct7 also holds shamt[5]; RV32 requires it clear.
                    3'b001: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = ALU_SLL;
                    end
                    3'b101: begin
                        w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                        w_op    = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: begin
                        w_legal = 1'b1;
                        w_op    = base_op(w_funct3);
                    end
                endcase
            end
            default: ;
        endcase

        // An illegal entry carries only its tag and the illegal flag.
        w_dec           = '0;
        w_dec.tag       = in_tag;
        w_dec.illegal   = ~w_legal;
        w_dec.reg_write = w_legal;
        if (w_legal) begin
            w_dec.alu_op  = w_op;
            w_dec.src_imm = w_imm;
            w_dec.mdu     = w_mdu;
        end
    end

    entry_t           r_out;
    entry_t           r_skid;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_illegal_count;

    logic w_accept;
    logic w_drain;

    assign w_accept = in_valid && !r_skid_valid && !flush;
    assign w_drain  = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out           <= '0;
            r_skid          <= '0;
            r_out_valid     <= 1'b0;
            r_skid_valid    <= 1'b0;
            r_illegal_count <= '0;
        end else begin
            // A handshake completes even on a flush cycle, so it is counted.
            if (w_drain && r_out.illegal && (r_illegal_count != '1)) begin
                r_illegal_count <= r_illegal_count + CNT_ONE;
            end

            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_out_valid || w_drain) begin
                // Output register is free this edge: the oldest entry moves in.
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= w_accept;
                    if (w_accept) begin
                        r_skid <= w_dec;
                    end
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) begin
                        r_out <= w_dec;
                    end
                end
            end else if (w_accept) begin
                // Output stalled: park the new entry in skid.
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign in_ready      = ~r_skid_valid;
    assign out_valid     = r_out_valid;
    assign out_alu_op    = r_out.alu_op;
    assign out_src_imm   = r_out.src_imm;
    assign out_reg_write = r_out.reg_write;
    assign out_mdu       = r_out.mdu;
    assign out_illegal   = r_out.illegal;
    assign out_tag       = r_out.tag;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage. Two instances share every input: u_dut_a has the
// M extension and a 16-bit counter, u_dut_b has no M extension and a 2-bit
// counter. The reference keeps accepted {tag, instr} words in a queue (at most
// two in flight) and decodes the head from the instruction-set rules.
module tb_rv_decode_stage;

    localparam int TAG_W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             a_in_ready, a_out_valid, a_src_imm, a_reg_write, a_mdu, a_illegal;
    logic [4:0]       a_alu_op;
    logic [TAG_W-1:0] a_tag;
    logic [15:0]      a_cnt;
    logic             b_in_ready, b_out_valid, b_src_imm, b_reg_write, b_mdu, b_illegal;
    logic [4:0]       b_alu_op;
    logic [TAG_W-1:0] b_tag;
    logic [1:0]       b_cnt;

    rv_decode_stage #(.ENABLE_M(1'b1), .TAG_W(TAG_W), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_alu_op(a_alu_op),
        .out_src_imm(a_src_imm), .out_reg_write(a_reg_write), .out_mdu(a_mdu),
        .out_illegal(a_illegal), .out_tag(a_tag), .illegal_count(a_cnt)
    );

    rv_decode_stage #(.ENABLE_M(1'b0), .TAG_W(TAG_W), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_alu_op(b_alu_op),
        .out_src_imm(b_src_imm), .out_reg_write(b_reg_write), .out_mdu(b_mdu),
        .out_illegal(b_illegal), .out_tag(b_tag), .illegal_count(b_cnt)
    );

    // ---------------- reference model ----------------
    int                  n_vec = 0;
    int                  n_err = 0;
    logic [TAG_W+31:0]   exp_q[$];
    logic [15:0]         cnt_a;
    logic [1:0]          cnt_b;

    // Returns {alu_op[4:0], src_imm, reg_write, mdu, illegal}.
    function automatic logic [8:0] ref_decode(input logic [31:0] ins, input bit en_m);
        int         base[8];
        logic [6:0] opc;
        logic [6:0] f7;
        int         f3;
        bit         legal;
        bit         imm;
        bit         mdu;
        int         op;
        base  = '{0, 2, 3, 4, 5, 6, 8, 9};
        opc   = ins[6:0];
        f7    = ins[31:25];
        f3    = int'(ins[14:12]);
        legal = 0; imm = 0; mdu = 0; op = 0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                legal = 1; op = base[f3];
            end else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
                legal = 1; op = base[f3] + 1;   // ADD->SUB, SRL->SRA
            end else if (f7 == 7'h01 && en_m) begin
                legal = 1; op = 16 + f3; mdu = 1;
            end
        end else if (opc == 7'h13) begin
            imm = 1;
            if (f3 == 1) begin
                legal = (f7 == 7'h00); op = 2;
            end else if (f3 == 5) begin
                legal = (f7 == 7'h00) || (f7 == 7'h20);
                op    = (f7 == 7'h20) ? 7 : 6;
            end else begin
                legal = 1; op = base[f3];
            end
        end
        if (!legal) begin
            op = 0; imm = 0; mdu = 0;
        end
        return {op[4:0], imm, legal, mdu, !legal};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all();
        logic [8:0]       da;
        logic [8:0]       db;
        logic [TAG_W-1:0] t;
        chk("a_in_ready", 32'(a_in_ready), 32'(exp_q.size() < 2));
        chk("b_in_ready", 32'(b_in_ready), 32'(exp_q.size() < 2));
        chk("a_out_valid", 32'(a_out_valid), 32'(exp_q.size() > 0));
        chk("b_out_valid", 32'(b_out_valid), 32'(exp_q.size() > 0));
        chk("a_count", 32'(a_cnt), 32'(cnt_a));
        chk("b_count", 32'(b_cnt), 32'(cnt_b));
        if (exp_q.size() > 0) begin
            da = ref_decode(exp_q[0][31:0], 1'b1);
            db = ref_decode(exp_q[0][31:0], 1'b0);
            t  = exp_q[0][TAG_W+31:32];
            chk("a_fields", 32'({a_alu_op, a_src_imm, a_reg_write, a_mdu, a_illegal}), 32'(da));
            chk("b_fields", 32'({b_alu_op, b_src_imm, b_reg_write, b_mdu, b_illegal}), 32'(db));
            chk("a_tag", 32'(a_tag), 32'(t));
            chk("b_tag", 32'(b_tag), 32'(t));
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: predict the edge from the current inputs, then check.
    task automatic cycle();
        bit         pop;
        bit         push;
        logic [8:0] d;
        pop  = (exp_q.size() > 0) && out_ready;
        push = in_valid && (exp_q.size() < 2) && !flush;
        if (pop) begin
            d = ref_decode(exp_q[0][31:0], 1'b1);
            if (d[0] && cnt_a != 16'hFFFF) cnt_a++;
            d = ref_decode(exp_q[0][31:0], 1'b0);
            if (d[0] && cnt_b != 2'b11) cnt_b++;
        end
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({in_tag, in_instr});
        end
        check_all();
    endtask

    task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tag;
        cycle();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        cnt_a = '0;
        cnt_b = '0;
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        chk("rst_a_count", 32'(a_cnt), 32'd0);
        chk("rst_b_count", 32'(b_cnt), 32'd0);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            4:       w[6:0] = 7'h03;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            2:       w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int          exp_b_seq[6];
        logic [31:0] lw;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        cnt_a     = '0;
        cnt_b     = '0;

        // Reset values
        #12;
        chk("reset_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("reset_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("reset_a_fields", 32'({a_alu_op, a_src_imm, a_reg_write, a_mdu, a_illegal}), 32'd0);
        chk("reset_a_tag", 32'(a_tag), 32'd0);
        chk("reset_a_count", 32'(a_cnt), 32'd0);
        chk("reset_b_count", 32'(b_cnt), 32'd0);
        rst = 1'b0;

        // Single decodes with no backpressure
        send(32'h003100B3, 5'd5);   // ADD
        chk("add_op", 32'(a_alu_op), 32'd0);
        chk("add_rw", 32'(a_reg_write), 32'd1);
        chk("add_imm", 32'(a_src_imm), 32'd0);
        chk("add_ill", 32'(a_illegal), 32'd0);
        chk("add_tag", 32'(a_tag), 32'd5);
        send(32'h403100B3, 5'd6);   // SUB
        chk("sub_op", 32'(a_alu_op), 32'd1);
        send(32'h40315093, 5'd7);   // SRAI
        chk("srai_op", 32'(a_alu_op), 32'd7);
        chk("srai_imm", 32'(a_src_imm), 32'd1);
        send(32'h023100B3, 5'd8);   // MUL
        chk("mul_op_m", 32'(a_alu_op), 32'd16);
        chk("mul_mdu_m", 32'(a_mdu), 32'd1);
        chk("mul_ill_nom", 32'(b_illegal), 32'd1);
        chk("mul_rw_nom", 32'(b_reg_write), 32'd0);
        in_valid = 1'b0;
        cycle();

        // Backpressure: tags 1, 2, 3 offered with downstream stalled
        out_ready = 1'b0;
        send(32'h003100B3, 5'd1);
        send(32'h003100B3, 5'd2);
        send(32'h003100B3, 5'd3);
        chk("bp_head_tag", 32'(a_tag), 32'd1);
        chk("bp_in_ready", 32'(a_in_ready), 32'd0);
        out_ready = 1'b1;
        cycle();
        chk("bp_second_tag", 32'(a_tag), 32'd2);
        cycle();
        chk("bp_third_tag", 32'(a_tag), 32'd3);
        in_valid = 1'b0;
        cycle();
        chk("bp_drained", 32'(a_out_valid), 32'd0);

        // Flush with both entries full and a new offer pending
        out_ready = 1'b0;
        send(32'h00315093, 5'd10);
        send(32'h00311093, 5'd11);
        flush = 1'b1;
        send(32'h003100B3, 5'd12);
        chk("flush_out_valid", 32'(a_out_valid), 32'd0);
        chk("flush_in_ready", 32'(a_in_ready), 32'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("flush_not_accepted", 32'(a_out_valid), 32'd0);

        // Saturating counter: five LWs with a clean counter
        async_reset();
        lw = 32'h0000A083;
        exp_b_seq = '{0, 1, 2, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) send(lw, 5'(i));
            else begin
                in_valid = 1'b0;
                cycle();
            end
            chk("cnt_b_seq", 32'(b_cnt), 32'(exp_b_seq[i]));
            chk("cnt_a_seq", 32'(a_cnt), 32'(i));
        end
        // Reset in the middle of a stream
        send(lw, 5'd20);
        send(lw, 5'd21);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_instr  = rand_instr();
            in_tag    = TAG_W'($urandom);
            cycle();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
